// File: rtl/fifomem_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifomem_wr_arbiter
// Controller for an external dual-port FIFO memory (DATASIZE x 2^ADDRSIZE,
// synchronous write with enable, combinational read). Two producers share the
// single write port under round-robin arbitration. The consumer pops through a
// first-word-fall-through interface: the head word appears on the memory read
// port at mem_raddr whenever rempty is low.
//
// Ports
//   wclk, wrst             clock; synchronous active-high reset
//   reqN_valid/data/ready  producer N handshake (ready = accepted this cycle)
//   rinc                   consumer pop request
//   mem_wdata/waddr/wclken memory write port drive
//   mem_raddr              memory read address (head of queue)
//   wfull, rempty, count   occupancy, all derived from registered pointers
//   last_grant             producer granted most recently
//   underflow              sticky: rinc seen while empty, cleared by wrst
// -----------------------------------------------------------------------------
module fifomem_wr_arbiter #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                req0_valid,
   input  logic [DATASIZE-1:0] req0_data,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [DATASIZE-1:0] req1_data,
   output logic                req1_ready,
   input  logic                rinc,
   output logic [DATASIZE-1:0] mem_wdata,
   output logic [ADDRSIZE-1:0] mem_waddr,
   output logic [ADDRSIZE-1:0] mem_raddr,
   output logic                mem_wclken,
   output logic                wfull,
   output logic                rempty,
   output logic [ADDRSIZE:0]   count,
   output logic                last_grant,
   output logic                underflow
);

   localparam logic [ADDRSIZE:0] PTR_ONE = {{ADDRSIZE{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ADDRSIZE:0] wptr_q, wptr_d;
   logic [ADDRSIZE:0] rptr_q, rptr_d;
   logic              last_grant_q, last_grant_d;
   logic              underflow_q, underflow_d;

   logic cand_vld;
   logic cand;       // 0 = producer 0, 1 = producer 1
   logic grant_ok;
   logic pop;

   // Flags come from registered pointers only, so a pop while full frees the
   // slot for writers one cycle later.
   always_comb begin
      wfull  = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
               (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);
      rempty = (wptr_q == rptr_q);
      count  = wptr_q - rptr_q;
   end

   // Round-robin: on contention the producer not granted last time wins.
   always_comb begin
      cand_vld = req0_valid | req1_valid;
      if (req0_valid && req1_valid) cand = ~last_grant_q;
      else                          cand = req1_valid;
      grant_ok   = cand_vld & ~wfull & ~wrst;
      req0_ready = grant_ok & ~cand;
      req1_ready = grant_ok &  cand;
      mem_wclken = grant_ok;
      mem_wdata  = cand ? req1_data : req0_data;
      mem_waddr  = wptr_q[ADDRSIZE-1:0];
      mem_raddr  = rptr_q[ADDRSIZE-1:0];
      pop        = rinc & ~rempty;
   end

   always_comb begin
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      last_grant_d = last_grant_q;
      underflow_d  = underflow_q | (rinc & rempty);
      if (grant_ok) begin
         wptr_d       = wptr_q + PTR_ONE;
         last_grant_d = cand;
      end
      if (pop) rptr_d = rptr_q + PTR_ONE;
   end

   // last_grant resets to 1 so producer 0 wins the first contention.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         last_grant_q <= 1'b1;
         underflow_q  <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         last_grant_q <= last_grant_d;
         underflow_q  <= underflow_d;
      end
   end

   assign last_grant = last_grant_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifomem_wr_arbiter.sv
module tb_fifomem_wr_arbiter;

   localparam int DS = 8;
   localparam int AS = 4;

   logic          wclk = 1'b0;
   logic          wrst;
   logic          req0_valid, req1_valid, rinc;
   logic [DS-1:0] req0_data, req1_data;
   logic          req0_ready, req1_ready;
   logic [DS-1:0] mem_wdata;
   logic [AS-1:0] mem_waddr, mem_raddr;
   logic          mem_wclken, wfull, rempty, last_grant, underflow;
   logic [AS:0]   count;

   int tests = 0;
   int fails = 0;

   fifomem_wr_arbiter #(.DATASIZE(DS), .ADDRSIZE(AS)) dut (
      .wclk(wclk), .wrst(wrst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .rinc(rinc),
      .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
      .mem_wclken(mem_wclken), .wfull(wfull), .rempty(rempty), .count(count),
      .last_grant(last_grant), .underflow(underflow)
   );

   always #5 wclk = ~wclk;

   // External memory the block drives: synchronous write, combinational read.
   logic [DS-1:0] mem [2**AS];
   logic [DS-1:0] rdata;
   always @(posedge wclk) if (mem_wclken) mem[mem_waddr] <= mem_wdata;
   assign rdata = mem[mem_raddr];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1, input logic ri);
      wrst = r; req0_valid = v0; req0_data = d0;
      req1_valid = v1; req1_data = d1; rinc = ri;
   endtask

   task automatic step();
      @(posedge wclk); #1;
   endtask

   // Inputs are applied just after an edge; expected outputs describe the
   // state before the next edge (registered state plus combinational response).
   typedef struct {
      logic       rst, v0;  logic [7:0] d0;
      logic       v1;       logic [7:0] d1;
      logic       ri;
      logic       r0, r1, wen; logic [7:0] wd;
      logic [4:0] cnt;
      logic       emp, full, lg, uf;
      logic       chk_rd; logic [7:0] rd;
   } vec_t;

   vec_t v [28];

   function automatic vec_t mk(logic rst, logic v0, logic [7:0] d0, logic v1, logic [7:0] d1,
                               logic ri, logic r0, logic r1, logic wen, logic [7:0] wd,
                               logic [4:0] cnt, logic emp, logic full, logic lg, logic uf,
                               logic chk_rd, logic [7:0] rd);
      vec_t t;
      t.rst = rst; t.v0 = v0; t.d0 = d0; t.v1 = v1; t.d1 = d1; t.ri = ri;
      t.r0 = r0; t.r1 = r1; t.wen = wen; t.wd = wd; t.cnt = cnt;
      t.emp = emp; t.full = full; t.lg = lg; t.uf = uf; t.chk_rd = chk_rd; t.rd = rd;
      return t;
   endfunction

   initial begin
      int sent, rcv, cnt_m;
      logic w, p;

      //        rst v0 d0    v1 d1    ri r0 r1 wen wd    cnt emp ful lg uf crd rd
      // req0 alone, then drain
      v[0]  = mk(1, 1, 8'h11, 0, 8'h00, 0, 0, 0, 0, 8'h11, 0, 1, 0, 1, 0, 0, 8'h00);
      v[1]  = mk(0, 1, 8'h11, 0, 8'h00, 0, 1, 0, 1, 8'h11, 0, 1, 0, 1, 0, 0, 8'h00);
      v[2]  = mk(0, 1, 8'h22, 0, 8'h00, 0, 1, 0, 1, 8'h22, 1, 0, 0, 0, 0, 1, 8'h11);
      v[3]  = mk(0, 1, 8'h33, 0, 8'h00, 0, 1, 0, 1, 8'h33, 2, 0, 0, 0, 0, 1, 8'h11);
      v[4]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3, 0, 0, 0, 0, 1, 8'h11);
      v[5]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 3, 0, 0, 0, 0, 1, 8'h11);
      v[6]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 2, 0, 0, 0, 0, 1, 8'h22);
      v[7]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h33);
      v[8]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00);
      // reset with last_grant=0, then contention alternates 0,1,0,1
      v[9]  = mk(1, 1, 8'hA0, 1, 8'hB0, 0, 0, 0, 0, 8'hB0, 0, 1, 0, 0, 0, 0, 8'h00);
      v[10] = mk(0, 1, 8'hA0, 1, 8'hB0, 0, 1, 0, 1, 8'hA0, 0, 1, 0, 1, 0, 0, 8'h00);
      v[11] = mk(0, 1, 8'hA1, 1, 8'hB0, 0, 0, 1, 1, 8'hB0, 1, 0, 0, 0, 0, 1, 8'hA0);
      v[12] = mk(0, 1, 8'hA1, 1, 8'hB1, 0, 1, 0, 1, 8'hA1, 2, 0, 0, 1, 0, 1, 8'hA0);
      v[13] = mk(0, 1, 8'hA2, 1, 8'hB1, 0, 0, 1, 1, 8'hB1, 3, 0, 0, 0, 0, 1, 8'hA0);
      v[14] = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 4, 0, 0, 1, 0, 1, 8'hA0);
      v[15] = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 3, 0, 0, 1, 0, 1, 8'hB0);
      v[16] = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 2, 0, 0, 1, 0, 1, 8'hA1);
      v[17] = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 8'hB1);
      v[18] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00);
      // req1 alone twice: no contention, req1 wins both regardless of last_grant
      v[19] = mk(0, 0, 8'h00, 1, 8'hC1, 0, 0, 1, 1, 8'hC1, 0, 1, 0, 1, 0, 0, 8'h00);
      v[20] = mk(0, 0, 8'h00, 1, 8'hC2, 0, 0, 1, 1, 8'hC2, 1, 0, 0, 1, 0, 1, 8'hC1);
      v[21] = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 2, 0, 0, 1, 0, 1, 8'hC1);
      v[22] = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 8'hC2);
      v[23] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00);
      // empty + write + rinc: write lands, pop ignored, underflow sticks
      v[24] = mk(0, 0, 8'h00, 1, 8'h5C, 1, 0, 1, 1, 8'h5C, 0, 1, 0, 1, 0, 0, 8'h00);
      v[25] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1, 1, 1, 8'h5C);
      v[26] = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 1, 1, 1, 8'h5C);
      v[27] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 1, 0, 8'h00);

      drive(1, 0, 0, 0, 0, 0);
      step();
      for (int i = 0; i < 28; i++) begin
         drive(v[i].rst, v[i].v0, v[i].d0, v[i].v1, v[i].d1, v[i].ri);
         @(negedge wclk);
         chk($sformatf("v%0d.r0", i),    req0_ready, v[i].r0);
         chk($sformatf("v%0d.r1", i),    req1_ready, v[i].r1);
         chk($sformatf("v%0d.wen", i),   mem_wclken, v[i].wen);
         chk($sformatf("v%0d.wdata", i), mem_wdata,  v[i].wd);
         chk($sformatf("v%0d.count", i), count,      v[i].cnt);
         chk($sformatf("v%0d.empty", i), rempty,     v[i].emp);
         chk($sformatf("v%0d.full", i),  wfull,      v[i].full);
         chk($sformatf("v%0d.lg", i),    last_grant, v[i].lg);
         chk($sformatf("v%0d.uf", i),    underflow,  v[i].uf);
         if (v[i].chk_rd) chk($sformatf("v%0d.rdata", i), rdata, v[i].rd);
         step();
      end

      // Fill to 16, pop while full with a pending write, then refill.
      drive(1, 0, 0, 0, 0, 0); step();
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 8'(8'h60 + i), 0, 0, 0); step();
      end
      drive(0, 1, 8'h70, 1, 8'h71, 0);
      @(negedge wclk);
      chk("full.flag", wfull, 1);
      chk("full.count", count, 16);
      chk("full.r0", req0_ready, 0);
      chk("full.r1", req1_ready, 0);
      step();
      drive(0, 1, 8'h70, 0, 0, 1);
      @(negedge wclk);
      chk("fullpop.r0", req0_ready, 0);
      chk("fullpop.wen", mem_wclken, 0);
      chk("fullpop.rdata", rdata, 8'h60);
      step();
      drive(0, 1, 8'h70, 0, 0, 0);
      @(negedge wclk);
      chk("afterpop.count", count, 15);
      chk("afterpop.full", wfull, 0);
      chk("afterpop.r0", req0_ready, 1);
      step();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge wclk);
      chk("refill.count", count, 16);
      chk("refill.full", wfull, 1);
      step();
      for (int i = 1; i < 17; i++) begin
         drive(0, 0, 0, 0, 0, 1);
         @(negedge wclk);
         chk($sformatf("drain%0d", i), rdata, (i == 16) ? 8'h70 : 8'(8'h60 + i));
         step();
      end
      drive(0, 0, 0, 0, 0, 0);
      @(negedge wclk);
      chk("drain.empty", rempty, 1);
      chk("drain.uf", underflow, 0);

      // Stream 40 words with concurrent pops across two address wraps.
      drive(1, 0, 0, 0, 0, 0); step();
      sent = 0; rcv = 0; cnt_m = 0;
      for (int cyc = 0; cyc < 200 && rcv < 40; cyc++) begin
         drive(0, sent < 40, 8'(8'h40 + sent), 0, 0, cnt_m > 0 && cyc % 5 != 3);
         @(negedge wclk);
         chk($sformatf("str%0d.count", cyc), count, cnt_m);
         w = req0_ready;
         p = rinc && !rempty;
         if (p) begin
            chk($sformatf("str.data%0d", rcv), rdata, 8'(8'h40 + rcv));
            rcv++;
         end
         if (w) sent++;
         cnt_m = cnt_m + int'(w) - int'(p);
         step();
      end
      chk("str.rcv", rcv, 40);
      chk("str.uf", underflow, 0);

      // Reset mid-stream with 7 queued, last grant to producer 0.
      drive(1, 0, 0, 0, 0, 0); step();
      for (int i = 0; i < 7; i++) begin
         drive(0, 1, 8'(i), 0, 0, 0); step();
      end
      drive(1, 1, 8'h99, 1, 8'h9A, 0);
      @(negedge wclk);
      chk("rst.pre_count", count, 7);
      chk("rst.pre_lg", last_grant, 0);
      chk("rst.r0", req0_ready, 0);
      chk("rst.r1", req1_ready, 0);
      chk("rst.wen", mem_wclken, 0);
      step();
      @(negedge wclk);
      chk("rst.count", count, 0);
      chk("rst.empty", rempty, 1);
      chk("rst.lg", last_grant, 1);
      chk("rst.wen2", mem_wclken, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
